// File: rtl/msi_bus.sv
// rtl/msi_bus.sv - MSI snooping-bus controller: round-robin arbitration, broadcast,
// snoop collection and memory sequencing.
module msi_bus #(
  parameter int NUM_CACHES = 2,
  parameter int ADDR_W     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CACHES-1:0]        req_valid_i,
  input  logic [2*NUM_CACHES-1:0]      req_msg_i,
  input  logic [ADDR_W*NUM_CACHES-1:0] req_addr_i,
  output logic [NUM_CACHES-1:0]        req_done_o,
  output logic [NUM_CACHES-1:0]        data_valid_o,
  output logic                         bus_valid_o,
  output logic [1:0]                   bus_msg_o,
  output logic [ADDR_W-1:0]            bus_addr_o,
  output logic [NUM_CACHES-1:0]        bus_src_o,
  input  logic [NUM_CACHES-1:0]        snoop_flush_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic                         mem_ack_i,
  output logic                         err_o
);

  localparam int WIN_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  localparam logic [1:0] MSG_RD    = 2'b00;
  localparam logic [1:0] MSG_RDX   = 2'b01;
  localparam logic [1:0] MSG_UPGR  = 2'b10;

  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MRD, DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]            msg_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [NUM_CACHES-1:0] src_q;
  logic [WIN_W-1:0]      last_q;

  logic                  grant_any;
  logic [WIN_W-1:0]      grant_idx;
  logic [NUM_CACHES-1:0] grant_oh;
  logic [1:0]            grant_msg;
  logic [ADDR_W-1:0]     grant_addr;
  int                    idx;

  logic [NUM_CACHES-1:0] hit;
  logic                  multi_hit;

  logic                  bus_valid_d;
  logic [NUM_CACHES-1:0] done_d, dv_d;
  logic                  mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_d;
  logic                  err_set;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_oh   = '0;
    grant_msg  = '0;
    grant_addr = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_CACHES; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_CACHES) idx = idx - NUM_CACHES;
      if (!grant_any && req_valid_i[idx]) begin
        grant_any     = 1'b1;
        grant_idx     = idx[WIN_W-1:0];
        grant_oh[idx] = 1'b1;
        grant_msg     = req_msg_i[2*idx +: 2];
        grant_addr    = req_addr_i[ADDR_W*idx +: ADDR_W];
      end
    end
  end

  assign hit       = snoop_flush_i & ~src_q;
  assign multi_hit = |(hit & (hit - 1'b1));

  always_comb begin
    state_d     = state_q;
    bus_valid_d = 1'b0;
    done_d      = '0;
    dv_d        = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d     = BCAST;
          bus_valid_d = 1'b1;
        end
      end
      BCAST: state_d = SNOOP;
      SNOOP: begin
        if (msg_q == MSG_UPGR) begin
          state_d = DONE;
          done_d  = src_q;
          err_set = |hit;
        end else begin
          err_set    = multi_hit;
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          // Flush always writes back; reads write back only when a peer holds it Modified.
          if (msg_q[1] || (|hit)) begin
            state_d  = WB;
            mem_we_d = 1'b1;
          end else begin
            state_d = MRD;
          end
        end
      end
      WB, MRD: begin
        if (mem_ack_i) begin
          state_d = DONE;
          done_d  = src_q;
          if (msg_q == MSG_RD || msg_q == MSG_RDX) dv_d = src_q;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = (state_q == WB);
          mem_addr_d = addr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      msg_q        <= '0;
      addr_q       <= '0;
      src_q        <= '0;
      last_q       <= WIN_W'(NUM_CACHES - 1);
      bus_valid_o  <= 1'b0;
      bus_msg_o    <= '0;
      bus_addr_o   <= '0;
      bus_src_o    <= '0;
      req_done_o   <= '0;
      data_valid_o <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_valid_o  <= bus_valid_d;
      bus_msg_o    <= bus_valid_d ? grant_msg  : '0;
      bus_addr_o   <= bus_valid_d ? grant_addr : '0;
      bus_src_o    <= bus_valid_d ? grant_oh   : '0;
      req_done_o   <= done_d;
      data_valid_o <= dv_d;
      mem_req_o    <= mem_req_d;
      mem_we_o     <= mem_we_d;
      mem_addr_o   <= mem_addr_d;
      err_o        <= err_o | err_set;
      if (state_q == IDLE && grant_any) begin
        msg_q  <= grant_msg;
        addr_q <= grant_addr;
        src_q  <= grant_oh;
        last_q <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_msi_bus.sv
// tb/tb_msi_bus.sv - directed table-driven bench for msi_bus.
module tb_msi_bus;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_done, data_valid, bus_src, flush;
  logic [3:0] req_msg, req_addr;
  logic       bus_valid, mem_req, mem_we, ack, err;
  logic [1:0] bus_msg, bus_addr, mem_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msi_bus #(.NUM_CACHES(2), .ADDR_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_msg_i(req_msg), .req_addr_i(req_addr),
    .req_done_o(req_done), .data_valid_o(data_valid),
    .bus_valid_o(bus_valid), .bus_msg_o(bus_msg), .bus_addr_o(bus_addr), .bus_src_o(bus_src),
    .snoop_flush_i(flush),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_ack_i(ack),
    .err_o(err)
  );

  typedef struct {
    int         src;
    logic [1:0] msg;
    logic [1:0] addr;
    logic [1:0] flush;
    int         done_cyc;
    logic       uses_mem;
    logic       we;
    logic       dv;
  } vec_t;

  localparam int NV = 6;
  vec_t vec[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t       v;
    logic [1:0] oh;
    logic       saw_mreq;
    logic [1:0] grants[3];
    int         n_bus, n_done;

    //           src msg    addr   flush  done mem we  dv
    vec[0] = '{1, 2'b10, 2'd2, 2'b00, 3, 1'b0, 1'b0, 1'b0};
    vec[1] = '{0, 2'b00, 2'd1, 2'b00, 4, 1'b1, 1'b0, 1'b1};
    vec[2] = '{0, 2'b00, 2'd1, 2'b01, 4, 1'b1, 1'b0, 1'b1};
    vec[3] = '{1, 2'b01, 2'd0, 2'b01, 4, 1'b1, 1'b1, 1'b1};
    vec[4] = '{0, 2'b11, 2'd3, 2'b00, 4, 1'b1, 1'b1, 1'b0};
    vec[5] = '{1, 2'b00, 2'd3, 2'b11, 4, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; req_valid = '0; req_msg = '0; req_addr = '0; flush = '0; ack = 1'b0;
    step(); step();
    chk("reset bus_valid", bus_valid, 0);
    chk("reset req_done", req_done, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      oh = 2'b01 << v.src;
      req_valid = oh; req_msg = {v.msg, v.msg}; req_addr = {v.addr, v.addr};
      flush = v.flush; ack = 1'b1; saw_mreq = 1'b0;
      for (int c = 1; c <= v.done_cyc; c++) begin
        step();
        if (mem_req) saw_mreq = 1'b1;
        if (c == 1) begin
          chk($sformatf("v%0d bus_valid", i), bus_valid, 1);
          chk($sformatf("v%0d bus_msg", i), bus_msg, v.msg);
          chk($sformatf("v%0d bus_addr", i), bus_addr, v.addr);
          chk($sformatf("v%0d bus_src", i), bus_src, oh);
        end
        if (c == 2) chk($sformatf("v%0d bus_valid drop", i), bus_valid, 0);
        if (c == 3 && v.uses_mem) begin
          chk($sformatf("v%0d mem_req", i), mem_req, 1);
          chk($sformatf("v%0d mem_we", i), mem_we, v.we);
          chk($sformatf("v%0d mem_addr", i), mem_addr, v.addr);
        end
        if (c == v.done_cyc) begin
          chk($sformatf("v%0d req_done", i), req_done, oh);
          chk($sformatf("v%0d data_valid", i), data_valid, v.dv ? oh : 2'b00);
          chk($sformatf("v%0d mem_req off", i), mem_req, 0);
        end else begin
          chk($sformatf("v%0d early done c%0d", i, c), req_done, 0);
        end
      end
      chk($sformatf("v%0d saw mem_req", i), saw_mreq, v.uses_mem);
      chk($sformatf("v%0d err", i), err, 0);
      req_valid = '0; flush = '0;
      step();
    end

    // Delayed ack: peer flush forces write-back held three cycles.
    req_valid = 2'b01; req_msg = 4'b0000; req_addr = 4'b0001; flush = 2'b10; ack = 1'b0;
    step(); step();
    for (int c = 3; c <= 5; c++) begin
      step();
      chk($sformatf("wb mem_req c%0d", c), mem_req, 1);
      chk($sformatf("wb mem_we c%0d", c), mem_we, 1);
      chk($sformatf("wb mem_addr c%0d", c), mem_addr, 1);
      chk($sformatf("wb no done c%0d", c), req_done, 0);
    end
    ack = 1'b1;
    step();
    chk("wb req_done", req_done, 2'b01);
    chk("wb data_valid", data_valid, 2'b01);
    chk("wb mem_req released", mem_req, 0);
    req_valid = '0; flush = '0;
    step();

    // Async reset mid-MRD; pointer would otherwise favour cache 1.
    req_valid = 2'b01; req_msg = 4'b0000; req_addr = 4'b0010; ack = 1'b0;
    step(); step(); step();
    chk("mrd mem_req before reset", mem_req, 1);
    chk("mrd mem_we", mem_we, 0);
    rst = 1'b1;
    #1;
    chk("async rst mem_req", mem_req, 0);
    chk("async rst done", req_done, 0);
    chk("async rst bus_valid", bus_valid, 0);
    step(); step();
    chk("dropped txn no done", req_done, 0);
    rst = 1'b0; req_valid = '0;
    step();

    // Both caches keep requesting BusRdX: grants must alternate 0,1,0.
    req_valid = 2'b11; req_msg = 4'b0101; req_addr = 4'b1001; ack = 1'b1;
    n_bus = 0; n_done = 0;
    for (int c = 0; c < 40 && n_done < 3; c++) begin
      step();
      if (bus_valid) begin
        if (n_bus < 3) grants[n_bus] = bus_src;
        n_bus++;
      end
      if (mem_req) chk("b2b mem_we", mem_we, 0);
      if (|req_done) begin
        chk($sformatf("b2b done%0d", n_done), req_done, grants[n_done]);
        chk($sformatf("b2b dv%0d", n_done), data_valid, grants[n_done]);
        n_done++;
      end
    end
    chk("b2b done count", n_done, 3);
    chk("b2b bus pulses", n_bus, 3);
    chk("b2b grant0", grants[0], 2'b01);
    chk("b2b grant1", grants[1], 2'b10);
    chk("b2b grant2", grants[2], 2'b01);
    req_valid = '0;
    step(); step();

    // BusUpgr with a peer flush: sticky error, still done at cycle 3.
    req_valid = 2'b10; req_msg = 4'b1000; req_addr = 4'b0000; flush = 2'b01; ack = 1'b1;
    step(); step();
    chk("upgr err before snoop", err, 0);
    step();
    chk("upgr err done", req_done, 2'b10);
    chk("upgr err dv", data_valid, 0);
    chk("upgr err set", err, 1);
    req_valid = '0; flush = '0;
    for (int c = 0; c < 5; c++) step();
    chk("err sticky", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
